alu_share_arb: RTL

Round-robin arbiter and result stage that shares the single 32-bit ALU between two requesters: the EX-stage integer path (port 0) and the address/branch-compare path (port 1). Each requester presents an ALU operation over a valid/ready handshake. The block grants one request per cycle, drives the shared ALU, and returns the result on one result channel tagged with source and requester tag. It sits between the EX-stage issue logic and the ALU instance.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/ALU.sv | 34 +++
 rtl/alu_share_arb.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sharing arbiter and the ALU itself:
//   - 3-bit ALU opcode encodings (ADD, SUB, OR, NOR, AND; 101..111 illegal)
//   - alu_op_legal(): true for the five defined opcodes
//   - result source encodings (EX integer path / address-branch path)
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_OR  = 3'b010;
    localparam alu_op_t ALU_NOR = 3'b011;
    localparam alu_op_t ALU_AND = 3'b100;

    // Result source port encoding
    localparam logic SRC_EX  = 1'b0;
    localparam logic SRC_AGU = 1'b1;

    // The legal opcodes are exactly the contiguous range 000..100.
    function automatic logic alu_op_legal(input alu_op_t op);
        return (op <= ALU_AND);
    endfunction

endpackage

// File: rtl/ALU.sv
// ---------------------------------------------------------------------------
// ALU
// Shared 32-bit combinational ALU. Arithmetic wraps modulo 2^32; there is no
// carry or overflow output. Illegal opcodes produce zero.
// Ports:
//   ALUop  in  3   operation select (alu_pkg encodings)
//   A      in  32  operand A
//   B      in  32  operand B
//   result out 32  operation result
// ---------------------------------------------------------------------------
module ALU
    import alu_pkg::*;
(
    input  logic [2:0]  ALUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result
);

    // NOTE: every signal written in always_comb gets a default on entry, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        result = '0;
        case (ALUop)
            ALU_ADD: result = A + B;
            ALU_SUB: result = A - B;
            ALU_OR:  result = A | B;
            ALU_NOR: result = ~(A | B);
            ALU_AND: result = A & B;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
// Round-robin arbiter sharing one ALU between the EX-stage integer path
// (port 0) and the address/branch-compare path (port 1). One request is
// granted per cycle; the result is returned on a single valid/ready channel
// tagged with the source port and the requester's tag.
//
// Build option: define ALU_ARB_OUTREG_EN for a one-entry registered result
// stage (latency 1). Without it the result path is combinational (latency 0)
// and the round-robin pointer is the only state.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   reqN_valid/reqN_ready           request handshake, N = 0 (EX), 1 (AGU)
//   reqN_op/reqN_a/reqN_b/reqN_tag  request payload
//   res_valid/res_ready             result handshake
//   res_data                        ALU result (0 for an illegal opcode)
//   res_src                         port that issued the request
//   res_tag                         tag of the originating request
//   res_err                         opcode was illegal
// ---------------------------------------------------------------------------
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);

    logic             last_grant;   // port granted on the last accepted transfer
    logic             win1;         // port 1 holds the grant this cycle
    logic             slot_free;    // result channel can take a new result
    logic             accept;

    logic [2:0]       sel_op;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      alu_result;
    logic             sel_err;
    logic [31:0]      sel_data;

    // On a tie the port that did not go last wins; otherwise the only valid
    // port wins. With no valid port win1 is 0 but no ready can rise.
    always_comb begin
        win1 = req1_valid;
        if (req0_valid && req1_valid) begin
            win1 = ~last_grant;
        end
    end

    // Readies are held low in reset so nothing is accepted in that cycle.
    assign req0_ready = rst_n & req0_valid & ~win1 & slot_free;
    assign req1_ready = rst_n & req1_valid &  win1 & slot_free;
    assign accept     = req0_ready | req1_ready;

    assign sel_op  = win1 ? req1_op  : req0_op;
    assign sel_a   = win1 ? req1_a   : req0_a;
    assign sel_b   = win1 ? req1_b   : req0_b;
    assign sel_tag = win1 ? req1_tag : req0_tag;

    ALU u_alu (
        .ALUop  (sel_op),
        .A      (sel_a),
        .B      (sel_b),
        .result (alu_result)
    );

    assign sel_err  = ~alu_op_legal(sel_op);
    assign sel_data = sel_err ? '0 : alu_result;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= SRC_AGU;
        end else if (accept) begin
            last_grant <= win1;
        end
    end

`ifdef ALU_ARB_OUTREG_EN

    assign slot_free = ~res_valid | res_ready;

    // NOTE: the payload fields are reset too, not only res_valid, because
    // their reset value of zero is part of the visible interface.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_src   <= SRC_EX;
            res_tag   <= '0;
            res_err   <= 1'b0;
        end else if (accept) begin
            // A load may coincide with the consumer taking the old entry.
            res_valid <= 1'b1;
            res_data  <= sel_data;
            res_src   <= win1;
            res_tag   <= sel_tag;
            res_err   <= sel_err;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

`else

    assign slot_free = res_ready;
    assign res_valid = req0_valid | req1_valid;
    assign res_data  = sel_data;
    assign res_src   = win1;
    assign res_tag   = sel_tag;
    assign res_err   = sel_err;

`endif

endmodule
